// File: rtl/prod_to_bcd.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) with a
// start/busy/done handshake; the result is held on bcd until the next completion.
module prod_to_bcd #(
  parameter int IN_W   = 18,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [0:0]            dbg_state
);

  localparam int CW = $clog2(IN_W + 1);
  localparam int BW = 4 * DIGITS;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  // Handshake: start is sampled only while idle; busy is high for the IN_W
  // shift cycles; done is a one-cycle pulse in which bcd first shows the result.
  logic [0:0]      state_q, state_d;
  logic [IN_W-1:0] sr_q, sr_d;
  logic [BW-1:0]   scr_q, scr_d;
  logic [BW-1:0]   adj;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;

  always_comb begin
    adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    if (state_q == S_IDLE) begin
      if (start) begin
        sr_d    = bin;
        scr_d   = '0;
        cnt_d   = CW'(IN_W);
        state_d = S_SHIFT;
      end
    end else begin
      scr_d = {adj[BW-2:0], sr_q[IN_W-1]};
      sr_d  = {sr_q[IN_W-2:0], 1'b0};
      cnt_d = cnt_q - CW'(1);
      // Last bit: publish the freshly shifted scratch directly to the output.
      if (cnt_q == CW'(1)) begin
        bcd_d   = scr_d;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q == S_SHIFT);
  assign done      = done_q;
  assign bcd       = bcd_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_prod_to_bcd.sv
// Bench for prod_to_bcd: vector table, random values against a decimal model,
// and hand-written sequences for mid-conversion changes, back-to-back and reset.
module tb_prod_to_bcd;

  logic        clk;
  logic        reset;
  logic        start;
  logic [17:0] bin;
  logic        busy;
  logic        done;
  logic [23:0] bcd;
  logic [0:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  prod_to_bcd #(.IN_W(18), .DIGITS(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bin       (bin),
    .busy      (busy),
    .done      (done),
    .bcd       (bcd),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [23:0] to_bcd(input int unsigned v);
    logic [23:0] r;
    int unsigned p;
    r = '0;
    p = 1;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  logic [23:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done (bounded); n counts edges since the call, bn counts busy samples.
  task automatic wait_done(output int n, output int bn,
                           input int chg_cyc = -1, input logic [17:0] chg_bin = '0,
                           input int pa = -1, input int pb = -1);
    n  = 0;
    bn = 0;
    while (!done && n < 40) begin
      if (busy) bn++;
      if (n == chg_cyc) bin = chg_bin;
      if (pa >= 0) start = (n == pa) || (n == pb);
      tick();
      n++;
    end
    if (pa >= 0) start = 1'b0;
    if (!done) check("done_timeout", 32'(n), 32'd18);
  endtask

  task automatic convert(input logic [17:0] v, output int n, output int bn,
                         input int chg_cyc = -1, input logic [17:0] chg_bin = '0,
                         input int pa = -1, input int pb = -1);
    bin   = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n, bn, chg_cyc, chg_bin, pa, pb);
  endtask

  // Watches k cycles and returns how many had busy or done high.
  task automatic idle_watch(input int k, output int act);
    act = 0;
    for (int i = 0; i < k; i++) begin
      tick();
      if (busy || done) act++;
    end
  endtask

  typedef struct {
    logic [17:0] bin;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int n, bn, act, n2;
    logic [17:0] r;

    vecs[0]  = '{18'd0,      24'h000000};
    vecs[1]  = '{18'd261121, 24'h261121};
    vecs[2]  = '{18'd262143, 24'h262143};
    vecs[3]  = '{18'd65025,  24'h065025};
    vecs[4]  = '{18'd1234,   24'h001234};
    vecs[5]  = '{18'd9,      24'h000009};
    vecs[6]  = '{18'd10,     24'h000010};
    vecs[7]  = '{18'd42,     24'h000042};
    vecs[8]  = '{18'd100,    24'h000100};
    vecs[9]  = '{18'd1,      24'h000001};
    vecs[10] = '{18'd99999,  24'h099999};
    vecs[11] = '{18'd131072, 24'h131072};

    reset = 1'b0;
    start = 1'b0;
    bin   = '0;
    #12;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_bcd", 32'(bcd), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // table-driven vectors with latency, busy length and one-cycle done
    for (int i = 0; i < 12; i++) begin
      convert(vecs[i].bin, n, bn);
      check($sformatf("vec%0d_bcd", i), 32'(bcd), 32'(vecs[i].exp));
      check($sformatf("vec%0d_latency", i), 32'(n), 32'd18);
      check($sformatf("vec%0d_busy_cycles", i), 32'(bn), 32'd18);
      tick();
      check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
      check($sformatf("vec%0d_bcd_held", i), 32'(bcd), 32'(vecs[i].exp));
    end

    // randomized values against the decimal model
    for (int i = 0; i < 30; i++) begin
      r = 18'($urandom_range(0, 262143));
      exp_q.push_back(to_bcd(r));
      convert(r, n, bn);
      check($sformatf("rand%0d_bcd(bin=%0d)", i, r), 32'(bcd), 32'(exp_q.pop_front()));
    end

    // bin changed mid-conversion is not resampled
    convert(18'd65025, n, bn, 3, 18'd7);
    check("bin_change_bcd", 32'(bcd), 32'h065025);

    // start pulses while busy are ignored
    convert(18'd1234, n, bn, 4, 18'd999, 5, 10);
    check("start_ignored_bcd", 32'(bcd), 32'h001234);
    check("start_ignored_latency", 32'(n), 32'd18);
    bin = 18'd999;
    idle_watch(25, act);
    check("start_ignored_no_second", 32'(act), 32'd0);

    // start held high: back-to-back conversions 19 cycles apart
    bin   = 18'd9;
    start = 1'b1;
    tick();
    check("b2b_state_shift", 32'(dbg_state), 32'd1);
    wait_done(n, bn);
    check("b2b_first_bcd", 32'(bcd), 32'h000009);
    bin = 18'd10;
    tick();
    wait_done(n2, bn);
    check("b2b_gap", 32'(n2 + 1), 32'd19);
    check("b2b_second_bcd", 32'(bcd), 32'h000010);
    start = 1'b0;
    tick();
    tick();

    // asynchronous reset mid-conversion
    convert(18'd42, n, bn);
    check("pre_reset_bcd", 32'(bcd), 32'h000042);
    bin   = 18'd555;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    #1;
    reset = 1'b0;
    #1;
    check("async_reset_busy", 32'(busy), 32'd0);
    check("async_reset_done", 32'(done), 32'd0);
    check("async_reset_bcd", 32'(bcd), 32'd0);
    #2;
    reset = 1'b1;
    idle_watch(25, act);
    check("after_reset_no_done", 32'(act), 32'd0);
    check("after_reset_bcd_zero", 32'(bcd), 32'd0);
    convert(18'd100, n, bn);
    check("after_reset_bcd", 32'(bcd), 32'h000100);
    check("after_reset_latency", 32'(n), 32'd18);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
